// File: rtl/mdu_flag_wb_pkg.sv
// Shared definitions for the MDU flag writeback path: XER bit layout and
// the packed layout of one pending-flag queue entry.
package mdu_flag_wb_pkg;

    localparam int XER_WIDTH = 32;
    localparam int XER_SO    = 31;
    localparam int XER_OV    = 30;
    localparam int XER_CA    = 29;

    // Wide enough for up to 16 CR fields; narrower indices are zero-extended.
    localparam int CRF_IDX_W = 4;

    typedef struct packed {
        logic                 ov;
        logic [2:0]           cmp;
        logic                 oe;
        logic                 rc;
        logic [CRF_IDX_W-1:0] crf;
    } flag_entry_t;

    localparam int ENTRY_W = $bits(flag_entry_t);

endpackage

// File: rtl/mdu_flag_fifo.sv
// Synchronous FIFO with occupancy count; flush empties it and blocks the
// same-edge push and pop.
module mdu_flag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone defines which slots are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mdu_flag_wb.sv
// Queues MDU overflow/compare flags and retires them into XER and CR one
// entry per commit, forwarding the previous cycle's write into the merge.
module mdu_flag_wb
    import mdu_flag_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NCRF  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_ov,
    input  logic [2:0]              in_cmp,
    input  logic                    in_oe,
    input  logic                    in_rc,
    input  logic [$clog2(NCRF)-1:0] in_crf,
    input  logic                    commit_en,
    input  logic                    flush,
    input  logic [XER_WIDTH-1:0]    xer_rd,
    input  logic [4*NCRF-1:0]       cr_rd,
    output logic                    xer_we,
    output logic [XER_WIDTH-1:0]    xer_wd,
    output logic                    cr_we,
    output logic [4*NCRF-1:0]       cr_wd,
    output logic [$clog2(DEPTH):0]  count
);

    flag_entry_t            in_entry;
    flag_entry_t            head;
    logic [ENTRY_W-1:0]     head_raw;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop_fire;

    logic [XER_WIDTH-1:0]   base_xer;
    logic [XER_WIDTH-1:0]   xer_new;
    logic [4*NCRF-1:0]      base_cr;
    logic [4*NCRF-1:0]      cr_new;
    logic                   so_new;

    logic                   xer_we_q, xer_we_d;
    logic [XER_WIDTH-1:0]   xer_wd_q, xer_wd_d;
    logic                   cr_we_q, cr_we_d;
    logic [4*NCRF-1:0]      cr_wd_q, cr_wd_d;

    assign in_entry = '{ov:  in_ov,
                        cmp: in_cmp,
                        oe:  in_oe,
                        rc:  in_rc,
                        crf: CRF_IDX_W'(in_crf)};

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop_fire = commit_en && !empty && !flush;
    assign head     = flag_entry_t'(head_raw);

    mdu_flag_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (commit_en),
        .wdata (in_entry),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A write still sitting in the output registers has not reached the
    // architectural copy yet, so it must be the base for the next merge.
    always_comb begin
        base_xer = xer_we_q ? xer_wd_q : xer_rd;
        base_cr  = cr_we_q  ? cr_wd_q  : cr_rd;

        xer_new = base_xer;
        if (head.oe) begin
            xer_new[XER_OV] = head.ov;
            xer_new[XER_SO] = base_xer[XER_SO] | head.ov;
        end
        so_new = xer_new[XER_SO];

        cr_new = base_cr;
        for (int f = 0; f < NCRF; f++) begin
            if (head.rc && (head.crf == CRF_IDX_W'(f))) begin
                cr_new[4*f +: 4] = {head.cmp, so_new};
            end
        end
    end

    always_comb begin
        xer_we_d = 1'b0;
        xer_wd_d = xer_wd_q;
        cr_we_d  = 1'b0;
        cr_wd_d  = cr_wd_q;
        if (pop_fire) begin
            xer_we_d = head.oe;
            cr_we_d  = head.rc;
            if (head.oe) begin
                xer_wd_d = xer_new;
            end
            if (head.rc) begin
                cr_wd_d = cr_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xer_we_q <= 1'b0;
            xer_wd_q <= '0;
            cr_we_q  <= 1'b0;
            cr_wd_q  <= '0;
        end else begin
            xer_we_q <= xer_we_d;
            xer_wd_q <= xer_wd_d;
            cr_we_q  <= cr_we_d;
            cr_wd_q  <= cr_wd_d;
        end
    end

    assign xer_we = xer_we_q;
    assign xer_wd = xer_wd_q;
    assign cr_we  = cr_we_q;
    assign cr_wd  = cr_wd_q;

endmodule

// File: tb/tb_mdu_flag_wb.sv
// Scoreboard bench for mdu_flag_wb: a behavioural queue model predicts the
// post-edge outputs of every cycle, which are compared one cycle later.
module tb_mdu_flag_wb;

    localparam int DEPTH = 4;
    localparam int NCRF  = 8;
    localparam int SO    = 31;
    localparam int OV    = 30;

    typedef struct packed {
        logic       ov;
        logic [2:0] cmp;
        logic       oe;
        logic       rc;
        logic [2:0] crf;
    } ent_t;

    typedef struct packed {
        logic        xer_we;
        logic [31:0] xer_wd;
        logic        cr_we;
        logic [31:0] cr_wd;
        logic [2:0]  count;
        logic        in_ready;
        logic        after_rst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ov;
    logic [2:0]  in_cmp;
    logic        in_oe;
    logic        in_rc;
    logic [2:0]  in_crf;
    logic        commit_en;
    logic        flush;
    logic [31:0] xer_rd;
    logic [31:0] cr_rd;
    logic        xer_we;
    logic [31:0] xer_wd;
    logic        cr_we;
    logic [31:0] cr_wd;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    ent_t mq[$];
    exp_t sb[$];
    logic        m_xwe = 1'b0;
    logic [31:0] m_xwd = '0;
    logic        m_cwe = 1'b0;
    logic [31:0] m_cwd = '0;

    mdu_flag_wb #(.DEPTH(DEPTH), .NCRF(NCRF)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ov     (in_ov),
        .in_cmp    (in_cmp),
        .in_oe     (in_oe),
        .in_rc     (in_rc),
        .in_crf    (in_crf),
        .commit_en (commit_en),
        .flush     (flush),
        .xer_rd    (xer_rd),
        .cr_rd     (cr_rd),
        .xer_we    (xer_we),
        .xer_wd    (xer_wd),
        .cr_we     (cr_we),
        .cr_wd     (cr_wd),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic ov, input logic [2:0] cmp,
                         input logic oe, input logic rc, input logic [2:0] crf);
        in_valid = v;
        in_ov    = ov;
        in_cmp   = cmp;
        in_oe    = oe;
        in_rc    = rc;
        in_crf   = crf;
    endtask

    // Predict the effect of the coming edge, then compare after it.
    task automatic tick();
        ent_t        e;
        exp_t        x;
        exp_t        got;
        logic [31:0] bx, bc, nx, nc;
        logic        acc, popf, nxwe, ncwe;
        x = '0;
        if (rst) begin
            mq.delete();
            m_xwe = 1'b0;
            m_xwd = '0;
            m_cwe = 1'b0;
            m_cwd = '0;
            x.after_rst = 1'b1;
        end else begin
            acc  = in_valid && (mq.size() < DEPTH);
            popf = commit_en && (mq.size() > 0) && !flush;
            nxwe = 1'b0;
            ncwe = 1'b0;
            if (popf) begin
                e  = mq[0];
                bx = m_xwe ? m_xwd : xer_rd;
                bc = m_cwe ? m_cwd : cr_rd;
                nx = bx;
                if (e.oe) begin
                    nx[OV] = e.ov;
                    nx[SO] = bx[SO] | e.ov;
                end
                nc = bc;
                if (e.rc) nc[4*e.crf +: 4] = {e.cmp, nx[SO]};
                nxwe = e.oe;
                ncwe = e.rc;
                if (e.oe) m_xwd = nx;
                if (e.rc) m_cwd = nc;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (popf) void'(mq.pop_front());
                if (acc) mq.push_back('{ov: in_ov, cmp: in_cmp, oe: in_oe, rc: in_rc, crf: in_crf});
            end
            m_xwe = nxwe;
            m_cwe = ncwe;
        end
        x.xer_we   = m_xwe;
        x.xer_wd   = m_xwd;
        x.cr_we    = m_cwe;
        x.cr_wd    = m_cwd;
        x.count    = 3'(mq.size());
        x.in_ready = (mq.size() < DEPTH);
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("count",    64'(count),    64'(got.count));
        chk("in_ready", 64'(in_ready), 64'(got.in_ready));
        chk("xer_we",   64'(xer_we),   64'(got.xer_we));
        chk("cr_we",    64'(cr_we),    64'(got.cr_we));
        if (got.xer_we || got.after_rst) chk("xer_wd", 64'(xer_wd), 64'(got.xer_wd));
        if (got.cr_we  || got.after_rst) chk("cr_wd",  64'(cr_wd),  64'(got.cr_wd));
    endtask

    initial begin
        rst = 1'b1;
        commit_en = 1'b0;
        flush = 1'b0;
        xer_rd = '0;
        cr_rd = '0;
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // single entry, both writes
        commit_en = 1'b1;
        xer_rd = 32'h2000_0000;
        cr_rd = 32'h0000_0000;
        drive(1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 3'd2);
        tick();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        chk("no_pop_on_push", 64'(xer_we | cr_we), 64'd0);
        tick();
        chk("d1_ov", 64'(xer_wd[OV]), 64'd1);
        chk("d1_so", 64'(xer_wd[SO]), 64'd1);
        chk("d1_ca_kept", 64'(xer_wd[29]), 64'd1);
        chk("d1_crf2", 64'(cr_wd[11:8]), 64'h9);
        tick();

        // back-to-back pops, SO forwarded from the in-flight write
        commit_en = 1'b0;
        xer_rd = 32'h0000_0000;
        cr_rd = 32'h1234_5678;
        drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 3'd5);
        tick();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        commit_en = 1'b1;
        tick();
        tick();
        chk("fwd_so", 64'(xer_wd[SO]), 64'd1);
        chk("fwd_ov", 64'(xer_wd[OV]), 64'd0);
        chk("fwd_crf5", 64'(cr_wd[23:20]), 64'h5);
        commit_en = 1'b0;
        tick();

        // fill to DEPTH, then push+pop on a full queue
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'(i), 3'(i), 1'b1, 1'(i), 3'(i + 1));
            tick();
        end
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'(DEPTH));
        drive(1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 3'd7);
        commit_en = 1'b1;
        tick();
        chk("full_pushpop", 64'(count), 64'(DEPTH - 1));
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < DEPTH + 1; i++) tick();

        // silent retire, then rc-only entry takes SO from xer_rd
        xer_rd = 32'h8000_0000;
        cr_rd = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 3'd1);
        tick();
        drive(1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 3'd6);
        tick();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        tick();
        chk("rc_only_xwe", 64'(xer_we), 64'd0);
        chk("rc_only_fld", 64'(cr_wd[27:24]), 64'h3);
        tick();

        // flush with three queued and one write in flight
        commit_en = 1'b0;
        xer_rd = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 3'(i));
            tick();
        end
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        commit_en = 1'b1;
        tick();
        flush = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 3'd3);
        tick();
        chk("flush_count", 64'(count), 64'd0);
        flush = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) tick();

        // reset mid-stream
        commit_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 3'(i));
            tick();
        end
        commit_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_we", 64'({xer_we, cr_we}), 64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
        tick();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            commit_en = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            xer_rd    = $urandom;
            cr_rd     = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_flag_wb.md
MDU_FLAG_WB -- requirements
Module: mdu_flag_wb

Interface
REQ-001 SHALL have parameter DEPTH, 4, entries in the pending-flag queue (power of two, 2..16).
REQ-002 SHALL have parameter NCRF, 8, number of 4-bit CR fields (CR width = 4*NCRF).
REQ-003 SHALL have ports: clk  in  1  sole clock; rising-edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  MDU result flags offered.
REQ-006 SHALL have ports: in_ready  out  1  queue can accept.
REQ-007 SHALL have ports: in_ov  in  1  MDU overflow.
REQ-008 SHALL have ports: in_cmp  in  3  {LT,GT,EQ} of the result.
REQ-009 SHALL have ports: in_oe  in  1  OE form.
REQ-010 SHALL have ports: in_rc  in  1  Rc form.
REQ-011 SHALL have ports: in_crf  in  clog2(NCRF)  target CR field.
REQ-012 SHALL have ports: commit_en  in  1  writeback stage may retire the head entry.
REQ-013 SHALL have ports: flush  in  1  discard all queued entries.
REQ-014 SHALL have ports: xer_rd  in  XER_WIDTH  architectural XER.
REQ-015 SHALL have ports: cr_rd  in  4*NCRF  architectural CR.
REQ-016 SHALL have ports: xer_we / xer_wd  out  1 / XER_WIDTH  XER write.
REQ-017 SHALL have ports: cr_we / cr_wd  out  1 / 4*NCRF  CR write.
REQ-018 SHALL have ports: count  out  clog2(DEPTH)+1  entries queued.

Function
REQ-019 SHALL push {ov,cmp,oe,rc,crf} on a rising edge where in_valid & in_ready.
REQ-020 SHALL drive in_ready = !full; it SHALL NOT depend on same-cycle pop.
REQ-021 SHALL pop the head on an edge where commit_en & !empty & !flush.
REQ-022 SHALL load xer_we/xer_wd/cr_we/cr_wd registers on the pop edge; outputs are valid the following cycle only (one-cycle pulse).
REQ-023 SHALL require an earliest write-pulse cycle of two edges after acceptance; an entry SHALL NOT be popped on its push edge.
REQ-024 SHALL use base XER = xer_we ? xer_wd : xer_rd and base CR = cr_we ? cr_wd : cr_rd (forwarding of the in-flight write).
REQ-025 SHALL compute, on pop with oe=1: OV = ov and SO = baseSO | ov; with oe=0: OV and SO taken from base.
REQ-026 SHALL keep CA and all other XER bits from base; bit positions SHALL be taken from XER_SO/XER_OV/XER_CA.
REQ-027 SHALL assert xer_we only when oe=1.
REQ-028 SHALL, on pop with rc=1, set CR field f = in_crf (bits 4f..4f+3) to {LT,GT,EQ,SO_new}, keep the other fields from base CR, and assert cr_we.
REQ-029 SHALL assert neither write enable on pop with oe=0 and rc=0 (entry retired silently).
REQ-030 SHALL, on flush, empty the queue (count=0) and ignore the same-edge push and pop; an in-flight write register SHALL still complete.
REQ-031 SHALL make simultaneous push and pop on a non-full queue leave count unchanged.
REQ-032 SHALL keep count exact at DEPTH; pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 SHALL, with rst high at an edge, set count=0, pointers=0, xer_we=0, cr_we=0, xer_wd=0 and cr_wd=0; in_ready SHALL be 1 the cycle after.
REQ-034 SHALL give reset priority over flush, push and pop, including mid-operation; queued entries are lost.

Structure
REQ-035 SHALL take XER_WIDTH and XER_* bit positions from SPR_def, and the entry field layout from arch_def.
REQ-036 SHALL use one sub-module, mdu_flag_fifo (parametrised sync FIFO with count), for the queue.

Verification
REQ-037 SHALL cover: push ov=1, oe=1, rc=1, crf=2, cmp=100 with xer_rd SO=0 -> one cycle later xer_wd OV=1, SO=1; cr_wd[8:11]=1001; both write enables pulse.
REQ-038 SHALL cover: two entries popped back-to-back, first ov=1/oe=1, second ov=0/oe=1/rc=1, with xer_rd held SO=0 -> second write has SO=1 (forwarded), OV=0.
REQ-039 SHALL cover: fill to DEPTH with commit_en=0 -> in_ready=0, count=DEPTH; then push+pop on the same edge -> count DEPTH-1, no push accepted.
REQ-040 SHALL cover: oe=0, rc=0 entry -> popped, no write enable; oe=0, rc=1 -> CR field SO equals xer_rd SO and xer_we=0.
REQ-041 SHALL cover: flush with 3 queued and one write in flight -> in-flight pulse occurs, count=0, no further writes.
REQ-042 SHALL cover: rst asserted mid-stream -> next cycle count=0, we=0, in_ready=1.
